rd53_afe_inj_seq: RTL and testbench

RD53_AFE_INJ_SEQ -- requirements
Module: rd53_afe_inj_seq

---
 rtl/rd53_afe_inj_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_rd53_afe_inj_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd53_afe_inj_seq.sv
// RD53 AFE injection sequencer: timed S0/S1 pulse bursts with discriminator hit counting.
// Optional ToT measurement of discriminator hits is enabled by defining RD53_AFE_INJ_TOT_EN.
module rd53_afe_inj_seq #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_num,
    input  logic             outdis,
    output logic             S0,
    output logic             S1,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] tot_last
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_pulses;
    logic [CNT_W-1:0] w_pulses_nxt;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_gap;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic             r_s0;
    logic             r_s1;
    logic             r_busy;
    logic             r_done;
    logic             w_s0_nxt;
    logic             w_s1_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_accept;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_hit_d;
    logic             w_hit_s;
    logic             w_rise;
    logic             w_active;
    logic [CNT_W-1:0] r_hit_cnt;

    // Programmed duration minus one; zero is treated as a one-cycle phase.
    function automatic logic [CNT_W-1:0] dur_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    assign w_accept = (r_state == ST_IDLE) && start && (cfg_sel != 2'b00) && !abort;
    assign w_sel_nxt = w_accept ? cfg_sel : r_sel;

    // Next-state and registered-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pulses_nxt = r_pulses;
        w_s0_nxt     = 1'b0;
        w_s1_nxt     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_pulses_nxt = (cfg_num == '0) ? CNT_W'(1) : cfg_num;
                    if (cfg_delay == '0) begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = dur_m1(cfg_width);
                    end else begin
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = cfg_delay - CNT_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = dur_m1(r_width);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = dur_m1(r_gap);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_pulses_nxt = r_pulses - CNT_W'(1);
                    if (r_pulses <= CNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = dur_m1(r_width);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over every transition; counters freeze where they are.
        if (abort) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = r_cnt;
            w_pulses_nxt = r_pulses;
        end

        w_s0_nxt   = (w_state_nxt == ST_PULSE) && w_sel_nxt[0];
        w_s1_nxt   = (w_state_nxt == ST_PULSE) && w_sel_nxt[1];
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pulses <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_sel    <= 2'b00;
            r_s0     <= 1'b0;
            r_s1     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pulses <= w_pulses_nxt;
            r_sel    <= w_sel_nxt;
            r_s0     <= w_s0_nxt;
            r_s1     <= w_s1_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            if (w_accept) begin
                r_width <= cfg_width;
                r_gap   <= cfg_gap;
            end
        end
    end

    // Discriminator synchroniser; outdis idles high so the flops reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hit_d <= 1'b0;
        end else begin
            r_sync1 <= outdis;
            r_sync2 <= r_sync1;
            r_hit_d <= w_hit_s;
        end
    end

    assign w_hit_s  = ~r_sync2;
    assign w_rise   = w_hit_s & ~r_hit_d;
    assign w_active = (r_state == ST_PULSE) || (r_state == ST_GAP) || (r_state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if (w_accept) begin
            r_hit_cnt <= '0;
        end else if (w_rise && w_active && !abort && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

`ifdef RD53_AFE_INJ_TOT_EN
    logic             w_fall;
    logic             r_tot_open;
    logic [CNT_W-1:0] r_tot;
    logic [CNT_W-1:0] r_tot_last;

    assign w_fall = ~w_hit_s & r_hit_d;

    // A hit only produces a ToT sample if it both opens and closes while the burst is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tot_open <= 1'b0;
            r_tot      <= '0;
            r_tot_last <= '0;
        end else if (abort || !w_active) begin
            r_tot_open <= 1'b0;
        end else if (w_rise) begin
            r_tot_open <= 1'b1;
            r_tot      <= CNT_W'(1);
        end else if (r_tot_open) begin
            if (w_fall) begin
                r_tot_last <= r_tot;
                r_tot_open <= 1'b0;
            end else if (w_hit_s && (r_tot != '1)) begin
                r_tot <= r_tot + CNT_W'(1);
            end
        end
    end

    assign tot_last = r_tot_last;
`else
    assign tot_last = '0;
`endif

    assign S0      = r_s0;
    assign S1      = r_s1;
    assign busy    = r_busy;
    assign done    = r_done;
    assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_rd53_afe_inj_seq.sv
// Directed bench for rd53_afe_inj_seq: per-cycle vector table plus hand-written hit/abort/reset sequences.
module tb_rd53_afe_inj_seq;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [CNT_W-1:0] cfg_num;
    logic             outdis;
    logic             S0;
    logic             S1;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] tot_last;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int st;
        int ab;
        int sel;
        int dly;
        int wid;
        int gap;
        int num;
        int e;      // expected {S0,S1,busy,done} after the edge
    } vec_t;

    vec_t vq[$];

    rd53_afe_inj_seq #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cfg_sel  (cfg_sel),
        .cfg_delay(cfg_delay),
        .cfg_width(cfg_width),
        .cfg_gap  (cfg_gap),
        .cfg_num  (cfg_num),
        .outdis   (outdis),
        .S0       (S0),
        .S1       (S1),
        .busy     (busy),
        .done     (done),
        .hit_cnt  (hit_cnt),
        .tot_last (tot_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int st, input int ab, input int sel, input int d, input int w,
                       input int g, input int n, input int e);
        vec_t v;
        v.st = st; v.ab = ab; v.sel = sel; v.dly = d; v.wid = w; v.gap = g; v.num = n; v.e = e;
        vq.push_back(v);
    endtask

    task automatic set_cfg(input int sel, input int d, input int w, input int g, input int n);
        cfg_sel   = 2'(sel);
        cfg_delay = CNT_W'(d);
        cfg_width = CNT_W'(w);
        cfg_gap   = CNT_W'(g);
        cfg_num   = CNT_W'(n);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic start_burst(input int sel, input int d, input int w, input int g, input int n);
        set_cfg(sel, d, w, g, n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_s0(input logic lvl, input int limit, input string name);
        int n = 0;
        while (S0 !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(S0), 32'(lvl));
    endtask

    initial begin
        int      n;
        logic    seen;
        int      exp_tot;

        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        outdis = 1'b1;
        set_cfg(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", 32'({S0, S1, busy, done}), 32'(0));
        check("reset_hit_cnt", 32'(hit_cnt), 32'(0));
        check("reset_tot_last", 32'(tot_last), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic S0 burst (d=3,w=4,g=2,n=2) with cfg scrambled and a stray start mid-burst.
        add(1, 0, 1, 3, 4, 2, 2, 4'b0010);
        add(0, 0, 2, 0, 1, 1, 1, 4'b0010);
        add(1, 0, 3, 0, 1, 1, 1, 4'b0010);
        for (int i = 0; i < 4; i++) add(0, 0, 2, 0, 1, 1, 1, 4'b1010);
        for (int i = 0; i < 2; i++) add(0, 0, 2, 0, 1, 1, 1, 4'b0010);
        for (int i = 0; i < 4; i++) add(0, 0, 2, 0, 1, 1, 1, 4'b1010);
        for (int i = 0; i < 2; i++) add(0, 0, 2, 0, 1, 1, 1, 4'b0010);
        add(0, 0, 2, 0, 1, 1, 1, 4'b0011);
        add(0, 0, 2, 0, 1, 1, 1, 4'b0000);
        // Start with sel=0 ignored; abort together with start ignored.
        add(1, 0, 0, 0, 1, 1, 1, 4'b0000);
        add(1, 1, 1, 0, 1, 1, 1, 4'b0000);
        add(0, 0, 0, 0, 1, 1, 1, 4'b0000);
        // All-zero timing config with both strobes.
        add(1, 0, 3, 0, 0, 0, 0, 4'b1110);
        add(0, 0, 0, 5, 5, 5, 5, 4'b0010);
        add(0, 0, 0, 5, 5, 5, 5, 4'b0011);
        add(0, 0, 0, 5, 5, 5, 5, 4'b0000);

        foreach (vq[i]) begin
            @(negedge clk);
            start = (vq[i].st != 0);
            abort = (vq[i].ab != 0);
            set_cfg(vq[i].sel, vq[i].dly, vq[i].wid, vq[i].gap, vq[i].num);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'({S0, S1, busy, done}), 32'(vq[i].e));
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;

        // Three 5-cycle discriminator hits, one inside each pulse.
        start_burst(1, 2, 8, 10, 3);
        for (int p = 0; p < 3; p++) begin
            wait_s0(1'b1, 40, $sformatf("hit_pulse%0d_up", p));
            outdis = 1'b0;
            repeat (5) @(negedge clk);
            outdis = 1'b1;
            wait_s0(1'b0, 40, $sformatf("hit_pulse%0d_dn", p));
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hit_done", 32'(done), 32'(1));
        @(negedge clk);
        check("hit_cnt3", 32'(hit_cnt), 32'(3));
`ifdef RD53_AFE_INJ_TOT_EN
        exp_tot = 5;
`else
        exp_tot = 0;
`endif
        check("tot_last", 32'(tot_last), 32'(exp_tot));
        check("hit_idle", 32'(busy), 32'(0));

        // Abort during the second pulse after one hit in the first.
        start_burst(1, 2, 8, 10, 3);
        wait_s0(1'b1, 40, "abort_p1_up");
        outdis = 1'b0;
        repeat (3) @(negedge clk);
        outdis = 1'b1;
        wait_s0(1'b0, 40, "abort_p1_dn");
        wait_s0(1'b1, 40, "abort_p2_up");
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ctl", 32'({S0, S1, busy, done}), 32'(0));
        check("abort_hit_cnt", 32'(hit_cnt), 32'(1));
        @(negedge clk);
        abort = 1'b0;
        start_burst(0, 0, 4, 4, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | busy | done | S0;
            @(negedge clk);
        end
        check("abort_sel0_ignored", 32'(seen), 32'(0));
        check("abort_hit_held", 32'(hit_cnt), 32'(1));

        // 300 hits saturate an 8-bit counter; then reset mid-pulse.
        start_burst(1, 0, 255, 255, 3);
        for (int h = 0; h < 300; h++) begin
            outdis = 1'b0;
            repeat (2) @(negedge clk);
            outdis = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("sat_busy", 32'(busy), 32'(1));
        check("sat_hit_cnt", 32'(hit_cnt), 32'(255));
        wait_s0(1'b1, 600, "sat_pulse_up");
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_s0", 32'(S0), 32'(0));
        check("rst_ctl", 32'({S0, S1, busy, done}), 32'(0));
        check("rst_hit_cnt", 32'(hit_cnt), 32'(0));
        check("rst_tot_last", 32'(tot_last), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'({S0, S1, busy, done}), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
